// File: rtl/ysyx_25060173_wbu.sv
// Write-back unit: selects the ALU result or extended load data, drives a registered
// register-file write port, and tracks pending writes per register for hazard detection.
module ysyx_25060173_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic                  iss_wen,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] q_rs1,
    input  logic [ADDR_WIDTH-1:0] q_rs2,
    output logic                  q_busy1,
    output logic                  q_busy2,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wen,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_sel,
    input  logic [DATA_WIDTH-1:0] in_alu,
    input  logic [DATA_WIDTH-1:0] in_ldata,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  ld_err
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [1:0]            pend_cnt [NREG];
    logic                  accept;
    logic                  issue_fire;
    logic [DATA_WIDTH-1:0] byte_sh;
    logic [DATA_WIDTH-1:0] half_sh;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  load_bad;
    logic [DATA_WIDTH-1:0] sel_val;

    assign in_ready   = ~rst;
    assign accept     = in_valid & in_ready;
    assign iss_ready  = ~(iss_wen && (pend_cnt[iss_rd] == 2'd3));
    assign issue_fire = iss_valid & iss_ready & iss_wen & (iss_rd != '0);
    assign q_busy1    = (pend_cnt[q_rs1] != 2'd0);
    assign q_busy2    = (pend_cnt[q_rs2] != 2'd0);

    assign byte_sh = in_ldata >> {in_addr_lo, 3'b000};
    assign half_sh = in_ldata >> {in_addr_lo[1], 4'b0000};

    always_comb begin
        load_val = '0;
        load_bad = 1'b0;
        case (in_funct3)
            3'b000:  load_val = {{(DATA_WIDTH-8){byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  load_val = {{(DATA_WIDTH-16){half_sh[15]}}, half_sh[15:0]};
            3'b010:  load_val = in_ldata;
            3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, byte_sh[7:0]};
            3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, half_sh[15:0]};
            default: load_bad = 1'b1;
        endcase
    end

    assign sel_val = in_sel ? load_val : in_alu;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            ld_err   <= 1'b0;
        end else if (accept) begin
            rf_we    <= in_wen & (in_rd != '0);
            rf_waddr <= in_rd;
            rf_wdata <= sel_val;
            ld_err   <= in_sel & load_bad;
        end else begin
            rf_we    <= 1'b0;
            ld_err   <= 1'b0;
        end
    end

    // Issue and retire on the same register in one edge cancel out; retire at 0 saturates.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            logic inc_hit;
            logic dec_hit;
            inc_hit = issue_fire && (iss_rd == i[ADDR_WIDTH-1:0]);
            dec_hit = rf_we && (rf_waddr == i[ADDR_WIDTH-1:0]);
            if (rst || i == 0) begin
                pend_cnt[i] <= 2'd0;
            end else if (inc_hit && !dec_hit) begin
                pend_cnt[i] <= pend_cnt[i] + 2'd1;
            end else if (dec_hit && !inc_hit && pend_cnt[i] != 2'd0) begin
                pend_cnt[i] <= pend_cnt[i] - 2'd1;
            end
        end
    end

endmodule

// File: doc/ysyx_25060173_wbu.md
# ysyx_25060173_wbu

Write-back unit of the ysyx_25060173 core, sitting directly upstream of the 32-entry register file. It accepts completed instructions from EXU/LSU over a valid/ready handshake, selects the ALU result or extracts and extends load data, and drives the register file's write port from a one-cycle registered stage. It also keeps a per-register pending-write scoreboard so the decoder can detect read-after-write hazards.

## Interface
- ADDR_WIDTH, 5, register address width; the scoreboard has 2^ADDR_WIDTH entries.
- DATA_WIDTH, 32, datapath width; load extraction is defined for 32 only.
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  the decoder issues an instruction this cycle.
- iss_wen  in  1  the issued instruction writes rd.
- iss_rd  in  ADDR_WIDTH  destination of the issued instruction.
- iss_ready  out  1  combinational; 0 when pending count of iss_rd is 3 and iss_wen=1.
- q_rs1, q_rs2  in  ADDR_WIDTH  hazard query addresses.
- q_busy1, q_busy2  out  1  combinational; pending count of q_rsN is non-zero.
- in_valid  in  1  a result is offered.
- in_ready  out  1  equals ~rst.
- in_wen  in  1  the result writes rd.
- in_rd  in  ADDR_WIDTH  destination.
- in_sel  in  1  0 = ALU result, 1 = load.
- in_alu  in  DATA_WIDTH  ALU or CSR result.
- in_ldata  in  DATA_WIDTH  raw aligned memory word.
- in_funct3  in  3  load type.
- in_addr_lo  in  2  low bits of the load address.
- rf_we  out  1  register file write enable, registered.
- rf_waddr  out  ADDR_WIDTH  registered.
- rf_wdata  out  DATA_WIDTH  registered.
- ld_err  out  1  registered; illegal load funct3 was retired.

## Operation
- Accept occurs when in_valid & in_ready.
- On accept at edge T:
  - rf_we <= in_wen & (in_rd != 0).
  - rf_waddr <= in_rd.
  - rf_wdata <= selected value.
  - ld_err <= in_sel & illegal funct3.
- With no accept, rf_we and ld_err are 0 in the next cycle. rf_waddr and rf_wdata hold their values.
- Load extraction: shift in_ldata right by 8*in_addr_lo for bytes. For halfwords, shift by 16*in_addr_lo[1].
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half.
  - 010 lw: whole word; in_addr_lo ignored.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - 011, 110, 111: data 0 and ld_err=1.
- Scoreboard: one 2-bit pending counter per register; counter 0 is constant 0.
  - Increment on iss_valid & iss_ready & iss_wen & (iss_rd != 0).
  - Decrement at the edge where rf_we=1 (the register file write edge), on rf_waddr.
  - The same register incremented and decremented on one edge stays unchanged.
  - Counters never wrap: iss_ready blocks increment at 3. Decrement at 0 is a protocol error; the counter saturates at 0.
- Issue and retire must agree on wen/rd. A non-writing or x0 instruction touches no counter.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, ld_err=0, all counters 0. in_ready=0 while rst=1.
- Reset mid-operation discards a staged write: rf_we=0 in the cycle after the reset edge.
- Latency: accept at edge T, rf_we high during cycle T..T+1, register file updated at edge T+1.
- Throughput: one result per cycle; back-to-back accepts give consecutive rf_we pulses.
- q_busy reflects counters after edge T+1. A read of rd in the cycle after the write edge sees new data with busy=0.
- The scoreboard drops to 0 only after the final outstanding write.

## Test plan
- Reset:
  - Stimulus: assert rst with in_valid=1.
  - Response: in_ready=0, rf_we=0, all q_busy=0.
  - Release rst, then accept ALU rd=5 data 0x1234_5678: rf_we=1, waddr=5, wdata=0x12345678 one cycle after accept.
- Load extraction:
  - Word 0x80FF_7F01, lb at addr_lo=3 -> 0xFFFF_FF80.
  - lbu at addr_lo=1 -> 0x0000_007F.
  - lh at addr_lo=2 -> 0xFFFF_80FF.
  - lhu at addr_lo=0 -> 0x0000_7F01.
  - lw -> 0x80FF7F01.
  - funct3=011 -> wdata 0, ld_err=1 for one cycle.
- Scoreboard:
  - Issue rd=7 three times: iss_ready=0 for a fourth rd=7, q_busy1(7)=1.
  - Retire three: busy clears only on the third rf_we edge.
  - Same-edge issue and retire on rd=7 leaves count unchanged.
- x0 / no-write:
  - Issue and retire with rd=0 or wen=0: rf_we=0 and no counter changes.
  - q_busy for x0 is always 0.
- Back-to-back accepts:
  - Accept rd=1,2,3 on consecutive cycles: three consecutive rf_we pulses with matching waddr/wdata.
- Reset mid-op:
  - Assert rst the cycle after an accept: rf_we=0 next cycle, counters cleared.
